// File: rtl/snake_vga_renderer.sv
// snake_vga_renderer
//   Display end of the snake pixel interface. Generates 640x480@60 VGA
//   timing, issues the current pixel coordinate to the game logic, takes back
//   the entity code for that pixel a fixed number of cycles later, and maps
//   it to 12-bit RGB. Sync and blank are delayed by the same amount so that
//   the pins line up. Also produces the per-step update strobe for the game.
//
// Ports
//   vga_clk      in   pixel clock, sole clock
//   reset_p      in   synchronous active-high reset
//   game_state   in   [2:0] `STATE_* code; colours only drawn in `STATE_INGAME
//   game_over    in   selects the game-over background colour
//   pause        in   freezes the step counter (no update_tick)
//   entity_in    in   [1:0] `ENT_* code for the coordinate issued ENT_LATENCY cycles ago
//   x_out/y_out  out  [9:0] raw h/v counters, to the game logic
//   hsync/vsync  out  active-low syncs, aligned with rgb
//   rgb          out  [11:0] {R,G,B} nibbles, 0 outside active video
//   frame_tick   out  1-cycle pulse while the counters sit at (0,480)
//   update_tick  out  1-cycle pulse on every FRAMES_PER_STEP-th unpaused frame_tick

`ifndef STATE_IDLE
`define STATE_IDLE     3'd0
`endif
`ifndef STATE_INGAME
`define STATE_INGAME   3'd1
`endif
`ifndef STATE_PAUSED
`define STATE_PAUSED   3'd2
`endif
`ifndef STATE_GAMEOVER
`define STATE_GAMEOVER 3'd3
`endif
`ifndef STATE_TEST
`define STATE_TEST     3'd4
`endif

`ifndef ENT_NOTHING
`define ENT_NOTHING    2'd0
`endif
`ifndef ENT_SNAKE_HEAD
`define ENT_SNAKE_HEAD 2'd1
`endif
`ifndef ENT_SNAKE_TAIL
`define ENT_SNAKE_TAIL 2'd2
`endif
`ifndef ENT_APPLE
`define ENT_APPLE      2'd3
`endif

module snake_vga_renderer #(
  parameter int          ENT_LATENCY     = 2,
  parameter int          FRAMES_PER_STEP = 6,
  parameter logic [11:0] COL_BG          = 12'h000,
  parameter logic [11:0] COL_HEAD        = 12'h0F0,
  parameter logic [11:0] COL_TAIL        = 12'h080,
  parameter logic [11:0] COL_APPLE       = 12'hF00,
  parameter logic [11:0] COL_OVER        = 12'h400
) (
  input  logic        vga_clk,
  input  logic        reset_p,
  input  logic [2:0]  game_state,
  input  logic        game_over,
  input  logic        pause,
  input  logic [1:0]  entity_in,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_tick,
  output logic        update_tick
);

  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_MAX    = 10'd524;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] HS_FIRST = 10'd656;
  localparam logic [9:0] HS_LAST  = 10'd751;
  localparam logic [9:0] VS_FIRST = 10'd490;
  localparam logic [9:0] VS_LAST  = 10'd491;
  localparam logic [5:0] STEP_MAX = 6'(FRAMES_PER_STEP - 1);

  logic [9:0]             h_cnt_q, h_cnt_d;
  logic [9:0]             v_cnt_q, v_cnt_d;
  logic [5:0]             step_cnt_q, step_cnt_d;
  logic [ENT_LATENCY-1:0] active_pipe_q, active_pipe_d;
  logic [ENT_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
  logic [ENT_LATENCY-1:0] vs_pipe_q, vs_pipe_d;
  logic [11:0]            rgb_q, rgb_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   frame_tick_q, frame_tick_d;
  logic                   update_tick_q, update_tick_d;

  logic                   active_raw, hs_raw, vs_raw;
  logic [11:0]            pixel_colour;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // The tick is decided from the next counter value so that the registered
  // pulse lands exactly on the cycle where the counters read (0,480).
  always_comb begin
    frame_tick_d  = (h_cnt_d == '0) && (v_cnt_d == V_ACTIVE);
    update_tick_d = 1'b0;
    step_cnt_d    = step_cnt_q;
    if (frame_tick_d && !pause) begin
      if (step_cnt_q == STEP_MAX) begin
        step_cnt_d    = '0;
        update_tick_d = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    active_raw = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
    hs_raw     = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_raw     = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  end

  // Delay lines: the top bit is in step with the entity code currently
  // presented on entity_in.
  always_comb begin
    active_pipe_d = ENT_LATENCY'({active_pipe_q, active_raw});
    hs_pipe_d     = ENT_LATENCY'({hs_pipe_q, hs_raw});
    vs_pipe_d     = ENT_LATENCY'({vs_pipe_q, vs_raw});
  end

  always_comb begin
    pixel_colour = COL_BG;
    if (game_state == `STATE_INGAME) begin
      case (entity_in)
        `ENT_SNAKE_HEAD: pixel_colour = COL_HEAD;
        `ENT_SNAKE_TAIL: pixel_colour = COL_TAIL;
        `ENT_APPLE:      pixel_colour = COL_APPLE;
        default:         pixel_colour = game_over ? COL_OVER : COL_BG;
      endcase
    end
    rgb_d   = active_pipe_q[ENT_LATENCY-1] ? pixel_colour : 12'h000;
    hsync_d = hs_pipe_q[ENT_LATENCY-1];
    vsync_d = vs_pipe_q[ENT_LATENCY-1];
  end

  always_ff @(posedge vga_clk) begin
    if (reset_p) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      step_cnt_q    <= '0;
      active_pipe_q <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_tick_q  <= 1'b0;
      update_tick_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      step_cnt_q    <= step_cnt_d;
      active_pipe_q <= active_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_tick_q  <= frame_tick_d;
      update_tick_q <= update_tick_d;
    end
  end

  assign x_out       = h_cnt_q;
  assign y_out       = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_tick  = frame_tick_q;
  assign update_tick = update_tick_q;

endmodule

// File: tb/tb_snake_vga_renderer.sv
// tb_snake_vga_renderer
//   Directed bench for snake_vga_renderer. To stay short, long stretches of
//   blanking are skipped by briefly forcing the h/v counter registers to a
//   chosen position; every expectation is then taken relative to the pixel
//   coordinates the bench itself has observed on x_out/y_out.

`timescale 1ns/1ps

`ifndef STATE_IDLE
`define STATE_IDLE     3'd0
`endif
`ifndef STATE_INGAME
`define STATE_INGAME   3'd1
`endif
`ifndef STATE_TEST
`define STATE_TEST     3'd4
`endif
`ifndef ENT_NOTHING
`define ENT_NOTHING    2'd0
`endif
`ifndef ENT_SNAKE_HEAD
`define ENT_SNAKE_HEAD 2'd1
`endif
`ifndef ENT_SNAKE_TAIL
`define ENT_SNAKE_TAIL 2'd2
`endif
`ifndef ENT_APPLE
`define ENT_APPLE      2'd3
`endif

module tb_snake_vga_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_p;
  logic [2:0]  game_state;
  logic        game_over;
  logic        pause;
  logic [1:0]  entity_in;
  logic [9:0]  x_out, y_out;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic        frame_tick, update_tick;

  int vectors     = 0;
  int miscompares = 0;

  logic       ent_model_mode;
  logic [1:0] ent_force;
  logic [1:0] ent_d1, ent_d2;
  logic [9:0] hx [4];
  logic [9:0] hy [4];
  logic [9:0] jump_h, jump_v;

  snake_vga_renderer #(
    .ENT_LATENCY     (2),
    .FRAMES_PER_STEP (6)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_p     (reset_p),
    .game_state  (game_state),
    .game_over   (game_over),
    .pause       (pause),
    .entity_in   (entity_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_tick  (frame_tick),
    .update_tick (update_tick)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] entAt(input logic [9:0] x, input logic [9:0] y);
    return (x >= 10'd16 && x <= 10'd31 && y >= 10'd32 && y <= 10'd47) ? `ENT_SNAKE_HEAD : `ENT_NOTHING;
  endfunction

  // One pixel clock: wait for the falling edge, present the entity for the
  // coordinate seen two cycles ago, and record the coordinate history.
  task automatic applyStimulus();
    @(negedge vga_clk);
    entity_in = ent_model_mode ? ent_d2 : ent_force;
    ent_d2 = ent_d1;
    ent_d1 = entAt(x_out, y_out);
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = x_out;
    hy[0] = y_out;
  endtask

  task automatic jumpTo(input logic [9:0] h, input logic [9:0] v);
    @(negedge vga_clk);
    jump_h = h;
    jump_v = v;
    force dut.h_cnt_q = jump_h;
    force dut.v_cnt_q = jump_v;
    #1;
    release dut.h_cnt_q;
    release dut.v_cnt_q;
  endtask

  task automatic waitFor(input logic [9:0] x, input logic [9:0] y, input int bound);
    int n = 0;
    while (!(x_out == x && y_out == y) && n < bound) begin
      applyStimulus();
      n++;
    end
    checkOutput("position reached", {y_out, x_out}, {y, x});
  endtask

  task automatic doFrame(input int f);
    int n = 0;
    pause = (f >= 7 && f <= 9);
    jumpTo(10'd795, 10'd479);
    while (!frame_tick && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput($sformatf("frame %0d tick", f), frame_tick, 1'b1);
    checkOutput($sformatf("frame %0d update", f), update_tick, (f == 6 || f == 15 || f == 21));
  endtask

  initial begin
    int n;
    int cnt;
    logic [9:0] x3, y3;

    reset_p        = 1'b1;
    game_state     = `STATE_IDLE;
    game_over      = 1'b0;
    pause          = 1'b0;
    ent_model_mode = 1'b0;
    ent_force      = `ENT_NOTHING;
    entity_in      = `ENT_NOTHING;
    ent_d1         = `ENT_NOTHING;
    ent_d2         = `ENT_NOTHING;
    jump_h         = '0;
    jump_v         = '0;
    for (int i = 0; i < 4; i++) begin
      hx[i] = '0;
      hy[i] = '0;
    end

    // Reset state
    repeat (4) applyStimulus();
    checkOutput("reset x_out", x_out, 10'd0);
    checkOutput("reset y_out", y_out, 10'd0);
    checkOutput("reset hsync", hsync, 1'b1);
    checkOutput("reset vsync", vsync, 1'b1);
    checkOutput("reset rgb", rgb, 12'h000);
    checkOutput("reset frame_tick", frame_tick, 1'b0);
    checkOutput("reset update_tick", update_tick, 1'b0);

    // Counters parked just before a frame tick: reset must suppress it
    jumpTo(10'd799, 10'd479);
    applyStimulus();
    checkOutput("no tick in reset", frame_tick, 1'b0);
    checkOutput("reset holds x", x_out, 10'd0);

    // Pixel latency with a constant apple
    game_state = `STATE_INGAME;
    ent_force  = `ENT_APPLE;
    applyStimulus();
    reset_p = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rgb before latency", rgb, 12'h000);
    applyStimulus();
    checkOutput("first pixel x", x_out, 10'd3);
    checkOutput("first pixel rgb", rgb, 12'hF00);

    waitFor(10'd640, 10'd0, 1000);
    applyStimulus();
    applyStimulus();
    checkOutput("last active rgb", rgb, 12'hF00);
    applyStimulus();
    checkOutput("first blank rgb", rgb, 12'h000);

    waitFor(10'd658, 10'd0, 100);
    checkOutput("hsync before pulse", hsync, 1'b1);
    applyStimulus();
    checkOutput("hsync pulse start", hsync, 1'b0);
    waitFor(10'd754, 10'd0, 200);
    checkOutput("hsync pulse end", hsync, 1'b0);
    applyStimulus();
    checkOutput("hsync after pulse", hsync, 1'b1);

    waitFor(10'd0, 10'd1, 1000);
    cnt = 0;
    repeat (800) begin
      applyStimulus();
      if (!hsync) cnt++;
    end
    checkOutput("hsync low per line", cnt, 96);

    // Entity stream as a 2-cycle-delayed function of (x,y): head on one cell
    ent_model_mode = 1'b1;
    jumpTo(10'd0, 10'd31);
    n = 0;
    while (y_out != 10'd49 && n < 16000) begin
      applyStimulus();
      n++;
      x3 = hx[3];
      y3 = hy[3];
      if (n >= 4 && (y3 == 10'd31 || y3 == 10'd32 || y3 == 10'd47 || y3 == 10'd48) &&
          (x3 == 10'd15 || x3 == 10'd16 || x3 == 10'd31 || x3 == 10'd32))
        checkOutput($sformatf("cell edge (%0d,%0d)", x3, y3), rgb,
                    (x3 >= 10'd16 && x3 <= 10'd31 && y3 >= 10'd32 && y3 <= 10'd47) ? 12'h0F0 : 12'h000);
    end
    checkOutput("grid scan done", y_out, 10'd49);
    ent_model_mode = 1'b0;

    // Colour map
    waitFor(10'd100, 10'd50, 2000);
    game_state = `STATE_TEST;
    ent_force  = `ENT_SNAKE_HEAD;
    repeat (4) applyStimulus();
    checkOutput("test state bg", rgb, 12'h000);
    game_state = `STATE_INGAME;
    repeat (4) applyStimulus();
    checkOutput("head colour", rgb, 12'h0F0);
    ent_force = `ENT_SNAKE_TAIL;
    repeat (4) applyStimulus();
    checkOutput("tail colour", rgb, 12'h080);
    ent_force = `ENT_APPLE;
    repeat (4) applyStimulus();
    checkOutput("apple colour", rgb, 12'hF00);
    ent_force = `ENT_NOTHING;
    game_over = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("game over bg", rgb, 12'h400);
    ent_force = `ENT_SNAKE_HEAD;
    repeat (4) applyStimulus();
    checkOutput("head over", rgb, 12'h0F0);
    ent_force = `ENT_NOTHING;
    waitFor(10'd700, 10'd50, 1000);
    checkOutput("blank during over", rgb, 12'h000);
    game_over = 1'b0;

    // Vertical sync width
    jumpTo(10'd0, 10'd488);
    waitFor(10'd3, 10'd489, 1000);
    cnt = 0;
    repeat (2400) begin
      applyStimulus();
      if (!vsync) cnt++;
    end
    checkOutput("vsync low per frame", cnt, 1600);

    // Frame tick placement and spacing
    jumpTo(10'd790, 10'd479);
    waitFor(10'd799, 10'd479, 20);
    checkOutput("tick early", frame_tick, 1'b0);
    applyStimulus();
    checkOutput("tick position", {y_out, x_out}, {10'd480, 10'd0});
    checkOutput("tick high", frame_tick, 1'b1);
    applyStimulus();
    checkOutput("tick one cycle", frame_tick, 1'b0);

    jumpTo(10'd0, 10'd479);
    n = 0;
    while (!frame_tick && n < 2000) begin
      applyStimulus();
      n++;
    end
    checkOutput("tick spacing from line start", n, 800);

    // Counter wraps
    jumpTo(10'd795, 10'd524);
    waitFor(10'd799, 10'd524, 10);
    applyStimulus();
    checkOutput("frame wrap", {y_out, x_out}, 20'd0);
    jumpTo(10'd798, 10'd10);
    applyStimulus();
    applyStimulus();
    checkOutput("line wrap", {y_out, x_out}, {10'd11, 10'd0});

    // Reset mid-frame
    ent_force = `ENT_APPLE;
    jumpTo(10'd290, 10'd200);
    waitFor(10'd300, 10'd200, 20);
    checkOutput("pre-reset rgb", rgb, 12'hF00);
    reset_p = 1'b1;
    applyStimulus();
    checkOutput("mid reset pos", {y_out, x_out}, 20'd0);
    checkOutput("mid reset rgb", rgb, 12'h000);
    checkOutput("mid reset hsync", hsync, 1'b1);
    checkOutput("mid reset vsync", vsync, 1'b1);
    checkOutput("mid reset tick", frame_tick, 1'b0);
    reset_p = 1'b0;
    applyStimulus();

    // Step counter with pause during frames 7..9
    for (int f = 1; f <= 21; f++) doFrame(f);
    pause = 1'b0;
    applyStimulus();
    checkOutput("update one cycle", update_tick, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
